// File: rtl/wdt_rcv_pkg.sv
// Shared definitions for the boot-watchdog recovery sequencer.
//   state_t   : FSM state encoding, also exported on o_state for debug
//   BLANK_CYC : ARMED cycles during which the WDT timeout flag is ignored
//   RETRY_W   : width of the retry counter
package wdt_rcv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_RESET   = 3'd2,
    ST_HOLDOFF = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAIL    = 3'd5
  } state_t;

  // Covers the WDT's 2-flop clear-edge detect after o_wdt_clr.
  localparam int unsigned BLANK_CYC = 4;

  localparam int unsigned RETRY_W = 4;

endpackage

// File: rtl/cyc_timer.sv
// Loadable down-counter shared by the RESET pulse, HOLDOFF wait and ARMED
// blanking window.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_load       : load i_load_val this cycle (takes priority over counting)
//   i_load_val   : value to load
//   o_done       : counter has reached zero (it then holds at zero)
module cyc_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_done = (cnt_q == '0);

endmodule

// File: rtl/bios_wdt_recovery.sv
// Boot-watchdog recovery sequencer. Arms the WDT, and on each timeout issues
// a timed system-reset request; after MAX_RETRY resets on the primary image
// it fails over to the backup flash, and after the backup is exhausted it
// latches a sticky failure until i_retry_clr.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_en           : recovery enable (level)
//   i_wdt_timeout  : WDT timeout flag (level)
//   i_boot_done    : BIOS POST complete (level)
//   i_retry_clr    : one-cycle pulse; clears retry count, releases FAIL
//   o_wdt_en       : WDT enable (high only in ARMED)
//   o_wdt_clr      : one-cycle WDT clear on each ARMED entry
//   o_sys_rst_req  : system reset request
//   o_flash_sel    : 0 = primary BIOS, 1 = backup
//   o_retry_cnt    : resets issued on the current image
//   o_fail         : sticky give-up flag
//   o_state        : current state encoding
// All outputs are registered from the next state so they move with o_state.
module bios_wdt_recovery
  import wdt_rcv_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC = 200,
  parameter int unsigned HOLDOFF_CYC   = 1000,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_wdt_timeout,
  input  logic               i_boot_done,
  input  logic               i_retry_clr,
  output logic               o_wdt_en,
  output logic               o_wdt_clr,
  output logic               o_sys_rst_req,
  output logic               o_flash_sel,
  output logic [RETRY_W-1:0] o_retry_cnt,
  output logic               o_fail,
  output logic [2:0]         o_state
);

  localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRY);

  // Counts run from load value down to 0 inclusive, so RESET/HOLDOFF load
  // length-1. The blanking load is BLANK_CYC so the first BLANK_CYC ARMED
  // cycles see a non-zero count.
  localparam logic [CNT_W-1:0] LD_RST   = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] LD_BLANK = CNT_W'(BLANK_CYC);

  state_t             state_q, state_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_base;
  logic               flash_q, flash_d;
  logic               wdt_en_q, wdt_clr_q, rst_req_q, fail_q;

  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_done;

  cyc_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .o_done     (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    flash_d = flash_q;
    // A clear outside FAIL zeroes the count before any same-cycle timeout
    // decision, so that timeout is judged against the cleared count.
    retry_base = (i_retry_clr && state_q != ST_FAIL) ? '0 : retry_q;
    retry_d    = retry_base;

    unique case (state_q)
      ST_IDLE: begin
        if (i_en) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!i_en) begin
          state_d = ST_IDLE;
        end else if (i_boot_done) begin
          state_d = ST_DONE;
        end else if (i_wdt_timeout && tmr_done) begin
          if (retry_base < MAX_R) begin
            retry_d = retry_base + RETRY_W'(1);
            state_d = ST_RESET;
          end else if (!flash_q) begin
            flash_d = 1'b1;
            retry_d = RETRY_W'(1);
            state_d = ST_RESET;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_RESET: begin
        // i_en is only consulted at expiry so the pulse is never cut short.
        if (tmr_done) state_d = i_en ? ST_HOLDOFF : ST_IDLE;
      end
      ST_HOLDOFF: begin
        if (!i_en)         state_d = ST_IDLE;
        else if (tmr_done) state_d = ST_ARMED;
      end
      ST_DONE: begin
        if (!i_en) state_d = ST_IDLE;
      end
      ST_FAIL: begin
        if (i_retry_clr) begin
          state_d = ST_IDLE;
          retry_d = '0;
          flash_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmr_load = (state_d != state_q);
    unique case (state_d)
      ST_ARMED:   tmr_val = LD_BLANK;
      ST_RESET:   tmr_val = LD_RST;
      ST_HOLDOFF: tmr_val = LD_HOLD;
      default:    tmr_val = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      retry_q   <= '0;
      flash_q   <= 1'b0;
      wdt_en_q  <= 1'b0;
      wdt_clr_q <= 1'b0;
      rst_req_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      flash_q   <= flash_d;
      wdt_en_q  <= (state_d == ST_ARMED);
      wdt_clr_q <= (state_d == ST_ARMED) && (state_q != ST_ARMED);
      rst_req_q <= (state_d == ST_RESET);
      fail_q    <= (state_d == ST_FAIL);
    end
  end

  assign o_state       = state_q;
  assign o_retry_cnt   = retry_q;
  assign o_flash_sel   = flash_q;
  assign o_wdt_en      = wdt_en_q;
  assign o_wdt_clr     = wdt_clr_q;
  assign o_sys_rst_req = rst_req_q;
  assign o_fail        = fail_q;

endmodule

// File: tb/tb_bios_wdt_recovery.sv
// Directed bench for bios_wdt_recovery with RST_PULSE_CYC=8, HOLDOFF_CYC=16,
// MAX_RETRY=2. Inputs are driven and outputs sampled 1 ns after each rising
// edge.
module tb_bios_wdt_recovery;

  localparam int unsigned RST_N  = 8;
  localparam int unsigned HOLD_N = 16;

  localparam logic [2:0] S_IDLE = 3'd0, S_ARMED = 3'd1, S_RESET = 3'd2,
                         S_HOLD = 3'd3, S_DONE  = 3'd4, S_FAIL  = 3'd5;

  logic       clk = 1'b0;
  logic       rst, en, tmo, boot, rclr;
  logic       wdt_en, wdt_clr, rst_req, flash, fail;
  logic [3:0] retry;
  logic [2:0] state;

  int unsigned errors = 0;
  int unsigned checks = 0;

  bios_wdt_recovery #(
    .RST_PULSE_CYC (RST_N),
    .HOLDOFF_CYC   (HOLD_N),
    .MAX_RETRY     (2),
    .CNT_W         (16)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .i_wdt_timeout (tmo),
    .i_boot_done   (boot),
    .i_retry_clr   (rclr),
    .o_wdt_en      (wdt_en),
    .o_wdt_clr     (wdt_clr),
    .o_sys_rst_req (rst_req),
    .o_flash_sel   (flash),
    .o_retry_cnt   (retry),
    .o_fail        (fail),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st);
    for (int i = 0; i < 200 && state !== st; i++) step();
    check(tag, 32'(state), 32'(st));
  endtask

  // Wait for ARMED, ride out the blanking window, then a one-cycle timeout.
  task automatic arm_and_timeout(input string tag);
    wait_state(tag, S_ARMED);
    repeat (5) step();
    tmo = 1'b1;
    step();
    tmo = 1'b0;
  endtask

  task automatic pulse_clr();
    rclr = 1'b1;
    step();
    rclr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    int unsigned clr_cnt;
    int unsigned rst_seen;

    rst = 1'b1; en = 1'b0; tmo = 1'b0; boot = 1'b0; rclr = 1'b0;
    repeat (3) step();
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_outs", {wdt_en, wdt_clr, rst_req, flash, fail, retry},
          32'd0);
    rst = 1'b0;
    step();

    // Clean boot
    en = 1'b1;
    step();
    check("boot_armed", 32'(state), 32'(S_ARMED));
    check("boot_clr", 32'(wdt_clr), 32'd1);
    check("boot_wdt_en", 32'(wdt_en), 32'd1);
    clr_cnt = 0; rst_seen = 0;
    repeat (49) begin
      step();
      clr_cnt  += 32'(wdt_clr);
      rst_seen += 32'(rst_req);
    end
    boot = 1'b1;
    step();
    check("boot_done_st", 32'(state), 32'(S_DONE));
    check("boot_wdt_en0", 32'(wdt_en), 32'd0);
    check("boot_retry", 32'(retry), 32'd0);
    check("boot_extra_clr", clr_cnt, 32'd0);
    check("boot_no_rst", rst_seen + 32'(rst_req), 32'd0);
    en = 1'b0; boot = 1'b0;
    step();
    check("boot_idle", 32'(state), 32'(S_IDLE));

    // Single retry
    en = 1'b1;
    step();
    repeat (9) step();
    tmo = 1'b1;
    step();
    tmo = 1'b0;
    check("retry_rst_state", 32'(state), 32'(S_RESET));
    check("retry_rst_req", 32'(rst_req), 32'd1);
    check("retry_cnt1", 32'(retry), 32'd1);
    check("retry_wdt_en0", 32'(wdt_en), 32'd0);
    n = 1;
    for (int i = 0; i < 100 && rst_req; i++) begin
      step();
      if (rst_req) n++;
    end
    check("retry_pulse_len", n, RST_N);
    check("retry_holdoff", 32'(state), 32'(S_HOLD));
    n = 1;
    for (int i = 0; i < 100 && state == S_HOLD; i++) begin
      step();
      if (state == S_HOLD) n++;
    end
    check("retry_hold_len", n, HOLD_N);
    check("retry_rearm", 32'(state), 32'(S_ARMED));
    check("retry_rearm_clr", 32'(wdt_clr), 32'd1);
    check("retry_rearm_cnt", 32'(retry), 32'd1);
    en = 1'b0;
    pulse_clr();
    check("retry_clr_idle", 32'(state), 32'(S_IDLE));
    check("retry_clr_cnt", 32'(retry), 32'd0);

    // Failover then fail
    en = 1'b1;
    arm_and_timeout("fo_t1");
    check("fo_t1_cnt", {flash, retry}, {1'b0, 4'd1});
    arm_and_timeout("fo_t2");
    check("fo_t2_cnt", {flash, retry}, {1'b0, 4'd2});
    arm_and_timeout("fo_t3");
    check("fo_t3_state", 32'(state), 32'(S_RESET));
    check("fo_t3_cnt", {flash, retry}, {1'b1, 4'd1});
    arm_and_timeout("fo_t4");
    check("fo_t4_cnt", {flash, retry}, {1'b1, 4'd2});
    arm_and_timeout("fo_t5");
    check("fo_fail_state", 32'(state), 32'(S_FAIL));
    check("fo_fail_outs", {fail, wdt_en, rst_req}, 32'b100);
    en = 1'b0;
    repeat (3) step();
    check("fo_fail_sticky", 32'(state), 32'(S_FAIL));
    pulse_clr();
    check("fo_clr_state", 32'(state), 32'(S_IDLE));
    check("fo_clr_outs", {wdt_en, wdt_clr, rst_req, flash, fail, retry},
          32'd0);

    // Blanking: timeout already high across ARMED entry
    tmo = 1'b1; en = 1'b1;
    step();
    check("blank_armed", 32'(state), 32'(S_ARMED));
    repeat (4) step();
    check("blank_ignored", 32'(state), 32'(S_ARMED));
    step();
    check("blank_acted", 32'(state), 32'(S_RESET));
    check("blank_rst_req", 32'(rst_req), 32'd1);
    tmo = 1'b0; en = 1'b0;
    wait_state("blank_idle", S_IDLE);
    pulse_clr();

    // Priority: boot_done wins over same-cycle timeout
    en = 1'b1;
    wait_state("prio_armed", S_ARMED);
    repeat (5) step();
    tmo = 1'b1; boot = 1'b1;
    step();
    tmo = 1'b0; boot = 1'b0;
    check("prio_done", 32'(state), 32'(S_DONE));
    check("prio_no_rst", {rst_req, retry}, 32'd0);
    en = 1'b0;
    step();

    // Disable at RESET cycle 3: pulse still full length, then IDLE
    en = 1'b1;
    arm_and_timeout("dis_rst");
    n = 1;
    repeat (2) begin
      step();
      n += 32'(rst_req);
    end
    en = 1'b0;
    for (int i = 0; i < 100 && rst_req; i++) begin
      step();
      if (rst_req) n++;
    end
    check("dis_rst_len", n, RST_N);
    check("dis_rst_idle", 32'(state), 32'(S_IDLE));

    // Disable during HOLDOFF: immediate IDLE
    en = 1'b1;
    arm_and_timeout("dis_hold_arm");
    wait_state("dis_hold_in", S_HOLD);
    repeat (3) step();
    en = 1'b0;
    step();
    check("dis_hold_idle", 32'(state), 32'(S_IDLE));
    check("dis_hold_wdt_en", 32'(wdt_en), 32'd0);

    // Async reset in RESET with backup selected
    pulse_clr();
    en = 1'b1;
    arm_and_timeout("ar_t1");
    arm_and_timeout("ar_t2");
    arm_and_timeout("ar_t3");
    check("ar_pre", {flash, rst_req}, 32'b11);
    step();
    #3 rst = 1'b1;
    #1;
    check("ar_state", 32'(state), 32'(S_IDLE));
    check("ar_outs", {wdt_en, wdt_clr, rst_req, flash, fail, retry},
          32'd0);
    #10 rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bios_wdt_recovery.md
# bios_wdt_recovery

Boot-watchdog recovery sequencer sitting directly downstream of the WDT timeout detector. It owns the WDT enable and clear, and consumes the WDT timeout flag. On each timeout it issues a timed system-reset request and retries boot up to a bounded count, then fails over from the primary to the backup BIOS flash. After the backup is also exhausted it latches a sticky failure for BMC reporting.

## Interface
- RST_PULSE_CYC, default 200: length of `o_sys_rst_req`, in `i_clk` cycles (≥1).
- HOLDOFF_CYC, default 1000: wait after reset release before re-arming (≥1).
- MAX_RETRY, default 3: resets allowed per flash image before failover (1..15).
- CNT_W, default 16: timer width; must hold max(RST_PULSE_CYC, HOLDOFF_CYC).
- `i_clk` input 1: system clock.
- `i_rst` input 1: asynchronous, active-high reset.
- `i_en` input 1: recovery enable (level).
- `i_wdt_timeout` input 1: WDT timeout flag (level, from WDT).
- `i_boot_done` input 1: BIOS POST complete (level, synchronous to `i_clk`).
- `i_retry_clr` input 1: one-cycle pulse; clears retry count and releases FAIL.
- `o_wdt_en` output 1: drives the WDT enable.
- `o_wdt_clr` output 1: one-cycle pulse; drives the WDT counter clear.
- `o_sys_rst_req` output 1: system reset request, active high.
- `o_flash_sel` output 1: 0 = primary BIOS, 1 = backup.
- `o_retry_cnt` output 4: resets issued on the current image.
- `o_fail` output 1: sticky give-up flag.
- `o_state` output 3: current state encoding, for debug.

## Operation
- States: IDLE=0, ARMED=1, RESET=2, HOLDOFF=3, DONE=4, FAIL=5.
- **IDLE:** `o_wdt_en`=0.
  - `i_en`=1 → ARMED.
- **ARMED:** `o_wdt_en`=1.
  - `o_wdt_clr`=1 in the first ARMED cycle only.
  - `i_wdt_timeout` is ignored for the first BLANK_CYC=4 ARMED cycles. This covers the WDT's 2-flop clear-edge detect.
  - `i_boot_done`=1 → DONE. This takes priority over a same-cycle timeout.
  - Timeout with `o_retry_cnt` < MAX_RETRY → `o_retry_cnt`+1, go to RESET.
  - Timeout with `o_retry_cnt` == MAX_RETRY and `o_flash_sel`=0 → `o_flash_sel`=1, `o_retry_cnt`=1, go to RESET. The failover reset counts as the first retry of the backup image.
  - Timeout with `o_retry_cnt` == MAX_RETRY and `o_flash_sel`=1 → FAIL.
- **RESET:** `o_sys_rst_req`=1, `o_wdt_en`=0.
  - After RST_PULSE_CYC cycles → HOLDOFF, or → IDLE if `i_en`=0 at expiry.
  - `i_en` dropping mid-pulse never truncates the pulse.
- **HOLDOFF:** `o_wdt_en`=0.
  - After HOLDOFF_CYC cycles → ARMED.
- **DONE:** `o_wdt_en`=0. `o_retry_cnt` and `o_flash_sel` are held.
- **FAIL:** `o_fail`=1, `o_wdt_en`=0, `o_sys_rst_req`=0.
  - `i_retry_clr` → IDLE, with `o_retry_cnt`=0, `o_flash_sel`=0, `o_fail`=0.
- **`i_en`=0:** forces IDLE from ARMED, HOLDOFF or DONE. FAIL ignores `i_en`. RESET completes its pulse first.
- **`i_retry_clr`:** in any state other than FAIL, sets `o_retry_cnt`=0 only. `o_flash_sel` is unchanged.
- **Timer:** loaded on state entry, counts down, expires at 0. Re-entering a state always reloads it.

## Timing
- All outputs are registered and decoded from the next state, so each output changes in the same cycle as `o_state`.
- **Reset values:** `o_state`=IDLE. `o_wdt_en`, `o_wdt_clr`, `o_sys_rst_req`, `o_flash_sel`, `o_fail` all 0. `o_retry_cnt`=0.
- **Latency, ARMED timeout → reset:** the timeout sample at cycle N (N ≥ 4 after ARMED entry) gives `o_sys_rst_req`=1 at N+1.
- `o_sys_rst_req` is high for exactly RST_PULSE_CYC consecutive cycles.
- HOLDOFF lasts exactly HOLDOFF_CYC cycles.
- `o_wdt_clr` is high for exactly one cycle per ARMED entry.
- **Reset mid-operation:** `i_rst` asserted in any state returns all outputs to reset values asynchronously. The flash selection is lost on reset.

## Structure
- Shared package `wdt_rcv_pkg` holds:
  - the state encoding constants;
  - BLANK_CYC=4;
  - the retry-count width (4).
- One sub-module, `cyc_timer`: a loadable CNT_W-bit down-counter with a `done` flag. It is shared by RESET, HOLDOFF and the ARMED blanking window.
- Main FSM and output registers live in `bios_wdt_recovery`.

## Test plan
Bench parameters: RST_PULSE_CYC=8, HOLDOFF_CYC=16, MAX_RETRY=2.
- **Clean boot:** `i_en`=1, `i_boot_done` after 50 cycles.
  - Expect one `o_wdt_clr` pulse, then DONE, `o_wdt_en`=0, `o_retry_cnt`=0, `o_sys_rst_req` never high.
- **Single retry:** timeout 10 cycles after ARMED.
  - Expect `o_sys_rst_req` high for exactly 8 cycles, then 16 cycles of HOLDOFF.
  - Expect a new `o_wdt_clr` pulse on re-arm and `o_retry_cnt`=1.
- **Failover then fail:** repeated timeouts.
  - After 2 resets on primary, the 3rd timeout sets `o_flash_sel`=1, `o_retry_cnt`=1.
  - The 2nd backup timeout enters FAIL with `o_fail`=1.
  - `i_retry_clr` then returns IDLE with all outputs 0.
- **Blanking and priority:**
  - Timeout held high across ARMED entry: ignored for 4 cycles, acted on in cycle 5.
  - `i_boot_done` and timeout in the same cycle: DONE, no reset.
- **Disable mid-sequence:**
  - `i_en`=0 at RESET cycle 3: the pulse still lasts 8 cycles, then IDLE.
  - `i_en`=0 during HOLDOFF: immediate IDLE.
- **Async reset:** `i_rst` pulsed in RESET with `o_flash_sel`=1.
  - All outputs return to 0 immediately, with no dependence on clock edges.
